// File: rtl/fetch_unit.sv
// fetch_unit: program-counter sequencer with conditional absolute/relative
// branches and an optional return-address stack for Call/Ret.
// Optional feature macro: FETCH_UNIT_RAS_EN enables the return stack.
// Without it, Call/Ret are ignored and Depth/Stack_ovf/Stack_unf read 0.
module fetch_unit #(
    parameter  int PC_W        = 10,
    parameter  int OFF_W       = 6,
    parameter  int STACK_DEPTH = 4,
    localparam int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
    input  logic               CLK,
    input  logic               Init,
    input  logic               Halt,
    input  logic               Branch_abs,
    input  logic               Branch_rel,
    input  logic               FLAG_IN,
    input  logic               Call,
    input  logic               Ret,
    input  logic [PC_W-1:0]    Target,
    input  logic [OFF_W-1:0]   Offset,
    output logic [PC_W-1:0]    PC,
    output logic [DEPTH_W-1:0] Depth,
    output logic               Stack_ovf,
    output logic               Stack_unf
);

    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_next;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_pc_rel;

    // Natural wrap of the PC width gives the modulo-2^PC_W behaviour.
    assign w_pc_inc = r_pc + 1'b1;
    // Relative base is the current PC; offset is sign-extended to PC width.
    assign w_pc_rel = r_pc + PC_W'($signed(Offset));

    assign PC = r_pc;

`ifdef FETCH_UNIT_RAS_EN
    localparam int               IDX_W    = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(STACK_DEPTH);

    logic [PC_W-1:0]    r_stack [STACK_DEPTH];
    logic [DEPTH_W-1:0] r_depth;
    logic [DEPTH_W-1:0] w_depth_next;
    logic               r_ovf;
    logic               r_unf;
    logic               w_ovf_next;
    logic               w_unf_next;
    logic               w_push;
    logic [IDX_W-1:0]   w_wr_idx;
    logic [IDX_W-1:0]   w_rd_idx;

    // Depth counts valid entries, so the free slot is at Depth and the top at Depth-1.
    assign w_wr_idx = IDX_W'(r_depth);
    assign w_rd_idx = IDX_W'(r_depth - 1'b1);

    // Next-state selection: Halt > Ret > Call > taken abs > taken rel > increment.
    always_comb begin
        w_pc_next    = w_pc_inc;
        w_depth_next = r_depth;
        w_ovf_next   = r_ovf;
        w_unf_next   = r_unf;
        w_push       = 1'b0;
        if (Halt) begin
            w_pc_next = r_pc;
        end else if (Ret) begin
            if (r_depth != '0) begin
                w_pc_next    = r_stack[w_rd_idx];
                w_depth_next = r_depth - 1'b1;
            end else begin
                w_unf_next = 1'b1;
            end
        end else if (Call) begin
            w_pc_next = Target;
            if (r_depth != DEPTH_FULL) begin
                w_push       = 1'b1;
                w_depth_next = r_depth + 1'b1;
            end else begin
                w_ovf_next = 1'b1;
            end
        end else if (Branch_abs && FLAG_IN) begin
            w_pc_next = Target;
        end else if (Branch_rel && FLAG_IN) begin
            w_pc_next = w_pc_rel;
        end
    end

    // Control state: PC, depth and sticky error flags, cleared asynchronously by Init.
    always_ff @(posedge CLK or posedge Init) begin
        if (Init) begin
            r_pc    <= '0;
            r_depth <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_pc    <= w_pc_next;
            r_depth <= w_depth_next;
            r_ovf   <= w_ovf_next;
            r_unf   <= w_unf_next;
        end
    end

    // Return-address storage; contents need no reset because Depth gates visibility.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_stack[w_wr_idx] <= w_pc_inc;
        end
    end

    assign Depth     = r_depth;
    assign Stack_ovf = r_ovf;
    assign Stack_unf = r_unf;
`else
    logic w_unused;

    // Call and Ret are accepted on the ports but have no effect in this build.
    assign w_unused = &{1'b0, Call, Ret};

    // Next-PC selection without a return stack: Halt > taken abs > taken rel > increment.
    always_comb begin
        w_pc_next = w_pc_inc;
        if (Halt) begin
            w_pc_next = r_pc;
        end else if (Branch_abs && FLAG_IN) begin
            w_pc_next = Target;
        end else if (Branch_rel && FLAG_IN) begin
            w_pc_next = w_pc_rel;
        end
    end

    // PC register, cleared asynchronously by Init.
    always_ff @(posedge CLK or posedge Init) begin
        if (Init) begin
            r_pc <= '0;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign Depth     = '0;
    assign Stack_ovf = 1'b0;
    assign Stack_unf = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a driver applies one request per cycle and
// pushes the reference model's predicted state; a monitor compares after each edge.
module tb_fetch_unit;
    localparam int PC_W  = 10;
    localparam int OFF_W = 6;
    localparam int SD    = 4;
    localparam int DW    = $clog2(SD + 1);
    localparam int MOD   = 1 << PC_W;

    logic             CLK = 1'b0;
    logic             Init = 1'b1;
    logic             Halt = 1'b0;
    logic             Branch_abs = 1'b0;
    logic             Branch_rel = 1'b0;
    logic             FLAG_IN = 1'b0;
    logic             Call = 1'b0;
    logic             Ret = 1'b0;
    logic [PC_W-1:0]  Target = '0;
    logic [OFF_W-1:0] Offset = '0;
    logic [PC_W-1:0]  PC;
    logic [DW-1:0]    Depth;
    logic             Stack_ovf;
    logic             Stack_unf;

    fetch_unit #(.PC_W(PC_W), .OFF_W(OFF_W), .STACK_DEPTH(SD)) dut (
        .CLK(CLK), .Init(Init), .Halt(Halt), .Branch_abs(Branch_abs),
        .Branch_rel(Branch_rel), .FLAG_IN(FLAG_IN), .Call(Call), .Ret(Ret),
        .Target(Target), .Offset(Offset), .PC(PC), .Depth(Depth),
        .Stack_ovf(Stack_ovf), .Stack_unf(Stack_unf)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int    pc;
        int    depth;
        bit    ovf;
        bit    unf;
        string tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: architectural state with a queue as the return stack.
    int m_pc = 0;
    int m_stack[$];
    bit m_ovf = 0;
    bit m_unf = 0;

    function automatic void model_reset();
        m_pc = 0;
        m_stack.delete();
        m_ovf = 0;
        m_unf = 0;
    endfunction

    function automatic void model_step(bit h, bit ba, bit br, bit fl, bit ca, bit re, int tgt, int off);
        bit done;
        done = 0;
        if (h) return;
`ifdef FETCH_UNIT_RAS_EN
        if (re) begin
            if (m_stack.size() > 0) m_pc = m_stack.pop_back();
            else begin
                m_pc  = (m_pc + 1) % MOD;
                m_unf = 1;
            end
            done = 1;
        end else if (ca) begin
            if (m_stack.size() < SD) m_stack.push_back((m_pc + 1) % MOD);
            else m_ovf = 1;
            m_pc = tgt;
            done = 1;
        end
`endif
        if (!done) begin
            if (ba && fl)      m_pc = tgt;
            else if (br && fl) m_pc = ((m_pc + off) % MOD + MOD) % MOD;
            else               m_pc = (m_pc + 1) % MOD;
        end
    endfunction

    // Apply one cycle of requests and record the model's prediction for the next edge.
    task automatic drive(bit h, bit ba, bit br, bit fl, bit ca, bit re, int tgt, int off, string tag);
        exp_t e;
        @(negedge CLK);
        Halt = h; Branch_abs = ba; Branch_rel = br; FLAG_IN = fl;
        Call = ca; Ret = re;
        Target = PC_W'(tgt);
        Offset = OFF_W'(off);
        model_step(h, ba, br, fl, ca, re, tgt, off);
        e.pc = m_pc; e.depth = m_stack.size(); e.ovf = m_ovf; e.unf = m_unf; e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic idle(string tag);
        drive(0, 0, 0, 0, 0, 0, 0, 0, tag);
    endtask

    // Immediate (clockless) check of the reset values.
    task automatic check_reset(string tag);
        n_checks++;
        if (PC !== '0 || Depth !== '0 || Stack_ovf !== 1'b0 || Stack_unf !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got pc=%0d depth=%0d ovf=%0b unf=%0b, required all 0",
                     tag, PC, Depth, Stack_ovf, Stack_unf);
        end else begin
            $display("ok   %s: pc=0 depth=0 flags clear", tag);
        end
    endtask

    // Mid-cycle Init pulse with conflicting requests held, spanning one clock edge.
    task automatic pulse_init(string tag);
        @(negedge CLK);
        #2;
        Halt = 1; Call = 1; Ret = 1; Branch_abs = 1; FLAG_IN = 1;
        Init = 1;
        #1;
        check_reset(tag);
        model_reset();
        @(posedge CLK);
        #2;
        Init = 0;
    endtask

    // Monitor: after every edge, pop the oldest prediction and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (PC !== PC_W'(e.pc) || Depth !== DW'(e.depth) ||
                    Stack_ovf !== e.ovf || Stack_unf !== e.unf) begin
                    n_fail++;
                    $display("FAIL %s: got pc=%0d depth=%0d ovf=%0b unf=%0b, required pc=%0d depth=%0d ovf=%0b unf=%0b",
                             e.tag, PC, Depth, Stack_ovf, Stack_unf, e.pc, e.depth, e.ovf, e.unf);
                end else begin
                    $display("ok   %s: pc=%0d depth=%0d ovf=%0b unf=%0b",
                             e.tag, PC, Depth, Stack_ovf, Stack_unf);
                end
            end
        end
    end

    initial begin
        int wait_cnt;
        model_reset();
        #1;
        check_reset("reset_at_start");
        @(negedge CLK);
        Init = 0;

        // Wrap from all-ones to zero.
        drive(0, 1, 0, 1, 0, 0, 1021, 0, "abs_to_1021");
        repeat (3) idle("wrap_run");

        // Relative branches and priority of abs over rel.
        drive(0, 1, 0, 1, 0, 0, 100, 0, "abs_to_100");
        drive(0, 0, 1, 1, 0, 0, 0, -4, "rel_minus4_taken");
        drive(0, 1, 0, 1, 0, 0, 100, 0, "abs_to_100");
        drive(0, 0, 1, 0, 0, 0, 0, -4, "rel_not_taken");
        drive(0, 1, 0, 1, 0, 0, 100, 0, "abs_to_100");
        drive(0, 1, 1, 1, 0, 0, 500, 7, "abs_beats_rel");
        drive(0, 1, 0, 0, 0, 0, 3, 0, "abs_not_taken");

        // Nested call/return.
        drive(0, 1, 0, 1, 0, 0, 10, 0, "abs_to_10");
        drive(0, 0, 0, 0, 1, 0, 200, 0, "call_200");
        drive(0, 0, 0, 0, 1, 0, 300, 0, "call_300");
        drive(0, 0, 0, 0, 0, 1, 0, 0, "ret_1");
        drive(0, 0, 0, 0, 0, 1, 0, 0, "ret_2");

        // Overflow and underflow around a full stack.
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 1, 0, 40 * (i + 1), 0, "call_nest");
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0, 1, 0, 0, "ret_unnest");

        // Halt dominates Call and Ret; Ret dominates Call and branches.
        drive(0, 0, 0, 0, 1, 0, 700, 0, "call_700");
        repeat (3) drive(1, 1, 1, 1, 1, 1, 55, 3, "halt_all");
        drive(0, 1, 0, 1, 1, 1, 9, 0, "ret_beats_call");

        // Call at PC=50 (falls through to increment without the stack).
        drive(0, 1, 0, 1, 0, 0, 50, 0, "abs_to_50");
        drive(0, 0, 0, 0, 1, 0, 123, 0, "call_at_50");

        // Async Init mid-run at PC=37, then restart from 0.
        drive(0, 1, 0, 1, 0, 0, 37, 0, "abs_to_37");
        pulse_init("init_at_37");
        repeat (3) idle("post_init");

        // Randomised traffic with occasional Init pulses.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(99) == 0) pulse_init("init_rand");
            drive($urandom_range(9) == 0, $urandom_range(4) == 0, $urandom_range(4) == 0,
                  $urandom_range(1) == 1, $urandom_range(6) == 0, $urandom_range(6) == 0,
                  int'($urandom_range(MOD - 1)), int'($urandom_range(63)) - 32, "random");
        end

        // Drain the scoreboard with a bounded wait.
        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 10) begin
            @(posedge CLK);
            wait_cnt++;
        end
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The module SHALL take parameter PC_W, default 10: program-counter width in bits.
REQ-002 The module SHALL take parameter OFF_W, default 6: signed relative-branch offset width in bits.
REQ-003 The module SHALL take parameter STACK_DEPTH, default 4: return-stack entries, at least 1.
REQ-004 Port CLK, input, 1: the single clock; all state changes on rising edge only.
REQ-005 Port Init, input, 1: reset; asynchronous, active-high.
REQ-006 Port Halt, input, 1: 1 freezes all state; 0 runs.
REQ-007 Port Branch_abs, input, 1: absolute branch request, qualified by FLAG_IN.
REQ-008 Port Branch_rel, input, 1: relative branch request, qualified by FLAG_IN.
REQ-009 Port FLAG_IN, input, 1: branch condition.
REQ-010 Port Call, input, 1: unconditional call to Target.
REQ-011 Port Ret, input, 1: unconditional return.
REQ-012 Port Target, input, PC_W: absolute target for Branch_abs and Call.
REQ-013 Port Offset, input, OFF_W: two's-complement offset for Branch_rel.
REQ-014 Port PC, output, PC_W: program counter, registered.
REQ-015 Port Depth, output, $clog2(STACK_DEPTH+1): valid return-stack entries.
REQ-016 Port Stack_ovf, output, 1: sticky flag, set by a Call when the stack is full.
REQ-017 Port Stack_unf, output, 1: sticky flag, set by a Ret when the stack is empty.

Function
REQ-018 Next-PC selection SHALL follow strict priority, one action per cycle: Halt > Ret > Call > (Branch_abs & FLAG_IN) > (Branch_rel & FLAG_IN) > increment.
REQ-019 On Halt=1, PC, stack, Depth and flags SHALL hold; all other inputs SHALL be ignored.
REQ-020 On increment, PC SHALL become PC+1 modulo 2^PC_W, so all-ones wraps to 0.
REQ-021 On a taken absolute branch, PC SHALL become Target on the next edge; latency is 1 cycle.
REQ-022 On a taken relative branch, PC SHALL become PC + sign-extended Offset, modulo 2^PC_W; the base is the current PC, not PC+1.
REQ-023 On Call with Depth<STACK_DEPTH, the unit SHALL push PC+1 (wrapped), set PC<=Target, and increment Depth.
REQ-024 On Call with Depth=STACK_DEPTH, the unit SHALL set PC<=Target, discard the push, leave Depth unchanged, and set Stack_ovf.
REQ-025 On Ret with Depth>0, the unit SHALL pop the top entry into PC and decrement Depth (LIFO order).
REQ-026 On Ret with Depth=0, the unit SHALL set PC<=PC+1, leave Depth at 0, and set Stack_unf.
REQ-027 Call and Ret asserted together SHALL perform Ret only; a simultaneous branch request SHALL be ignored.
REQ-028 Stack_ovf and Stack_unf SHALL stay set until Init.

Reset
REQ-029 Init=1 SHALL immediately, without waiting for a clock edge, force PC=0, Depth=0, Stack_ovf=0 and Stack_unf=0.
REQ-030 Init SHALL override Halt and every request, and SHALL abort any operation in progress.
REQ-031 The first edge after Init deasserts SHALL apply normal priority starting from PC=0.
REQ-032 Stack entry contents SHALL be don't-care after reset; they are never observable because Depth=0.

Configuration
REQ-033 The return-stack feature SHALL be controlled by macro FETCH_UNIT_RAS_EN.
REQ-034 With FETCH_UNIT_RAS_EN defined, REQ-023 to REQ-028 SHALL apply.
REQ-035 Without FETCH_UNIT_RAS_EN:
- no stack storage;
- Call and Ret SHALL be ignored, and priority falls through to branch or increment;
- Depth, Stack_ovf and Stack_unf SHALL be tied 0;
- ports SHALL be unchanged.

Verification
REQ-036 Init pulse mid-run at PC=37, then 3 idle cycles -> PC reads 0 asynchronously, then 1, 2, 3.
REQ-037 PC_W=10, run from 1021 with no requests -> 1022, 1023, 0.
REQ-038 At PC=100:
- Branch_rel, Offset=-4, FLAG_IN=1 -> PC=96;
- same request with FLAG_IN=0 -> PC=101;
- Branch_abs and Branch_rel both taken, Target=500 -> PC=500.
REQ-039 PC=10 Call Target=200; PC=200 Call Target=300; Ret; Ret -> PC sequence 200, 300, 201, 11; Depth 1, 2, 1, 0.
REQ-040 STACK_DEPTH=4, five nested Calls, then five Rets:
- Stack_ovf=1 after the fifth Call, Depth holds at 4;
- four Rets return the most recent four return addresses;
- the fifth Ret sets Stack_unf and increments PC.
REQ-041 Halt=1 asserted together with Call and Ret for 3 cycles -> PC and Depth unchanged.
REQ-042 Build without FETCH_UNIT_RAS_EN, Call at PC=50 -> PC=51 and Depth=0.
